// File: rtl/pixel_proc_pkg.sv
// pixel_proc_pkg: shared encodings for the pixel_proc_stream block.
//   mode_e  : per-pixel operation select (cfg_mode encodings; 6 and 7 are pass-through)
//   state_e : frame sequencing FSM states
package pixel_proc_pkg;

    typedef enum logic [2:0] {
        MODE_PASS   = 3'd0,
        MODE_ADD    = 3'd1,
        MODE_SUB    = 3'd2,
        MODE_GRAY   = 3'd3,
        MODE_INV    = 3'd4,
        MODE_THRESH = 3'd5
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/pix_op.sv
// pix_op: purely combinational per-pixel arithmetic unit.
// Ports:
//   mode            in  3   operation select (mode_e encodings)
//   value           in  DW  brightness offset / threshold
//   in_r/in_g/in_b  in  DW  source pixel
//   out_r/g/b       out DW  processed pixel
// Optional feature: define THRESHOLD_EN to build the mode-5 threshold
// comparator; without it mode 5 is pass-through.
module pix_op
    import pixel_proc_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [2:0]    mode,
    input  logic [DW-1:0] value,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_g,
    input  logic [DW-1:0] in_b,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_g,
    output logic [DW-1:0] out_b
);

    localparam int SW = DW + 2;

    logic [SW-1:0] sum3;
    logic [DW-1:0] gray;
    logic [DW-1:0] thresh;

    // 3*(2^DW-1) fits in DW+2 bits, and the quotient always fits back in DW.
    assign sum3 = {2'b00, in_r} + {2'b00, in_g} + {2'b00, in_b};
    assign gray = DW'(sum3 / SW'(3));

`ifdef THRESHOLD_EN
    assign thresh = (gray > value) ? '1 : '0;
`else
    assign thresh = '0;
`endif

    function automatic logic [DW-1:0] ch_op(
        input logic [2:0]    m,
        input logic [DW-1:0] x,
        input logic [DW-1:0] v,
        input logic [DW-1:0] g,
        input logic [DW-1:0] t
    );
        logic [SW-1:0] add_s;
        logic [SW-1:0] sub_s;
        logic [DW-1:0] res;
        add_s = {2'b00, x} + {2'b00, v};
        sub_s = {2'b00, x} - {2'b00, v};
        res   = x;
        case (m)
            // Carry into bit DW means the sum passed 2^DW-1.
            MODE_ADD:  res = add_s[DW] ? '1 : add_s[DW-1:0];
            // Both operands are < 2^DW, so a set MSB means a borrow.
            MODE_SUB:  res = sub_s[SW-1] ? '0 : sub_s[DW-1:0];
            MODE_GRAY: res = g;
            MODE_INV:  res = ~x;
`ifdef THRESHOLD_EN
            MODE_THRESH: res = t;
`endif
            default:   res = x;
        endcase
`ifndef THRESHOLD_EN
        res = res | (t & '0);
`endif
        return res;
    endfunction

    always_comb begin
        out_r = ch_op(mode, in_r, value, gray, thresh);
        out_g = ch_op(mode, in_g, value, gray, thresh);
        out_b = ch_op(mode, in_b, value, gray, thresh);
    end

endmodule

// File: rtl/pixel_proc_stream.sv
// pixel_proc_stream: frame-based streaming pixel processor.
// A start pulse in IDLE latches the frame config; width*height pixels are then
// accepted over a valid/ready input, processed by pix_op across a 2-stage
// pipeline, and emitted with row/col coordinates over a valid/ready output.
// Ports:
//   HCLK, HRESETn                 clock, async active-low reset
//   start, cfg_mode/value/width/height   frame start + config (latched on start)
//   in_valid/in_ready, in_r/g/b   input pixel stream
//   out_valid/out_ready, out_r/g/b, out_row/out_col, out_last   output stream
//   busy, done                    frame status (done is a 1-cycle pulse)
// Optional feature: THRESHOLD_EN enables the mode-5 threshold in pix_op.
module pixel_proc_stream #(
    parameter int DW         = 8,
    parameter int MAX_WIDTH  = 768,
    parameter int MAX_HEIGHT = 512,
    parameter int CW         = 11
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          start,
    input  logic [2:0]    cfg_mode,
    input  logic [DW-1:0] cfg_value,
    input  logic [CW-1:0] cfg_width,
    input  logic [CW-1:0] cfg_height,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_g,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_g,
    output logic [DW-1:0] out_b,
    output logic [CW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_last,
    output logic          busy,
    output logic          done
);
    import pixel_proc_pkg::*;

    localparam int STAGES = 2;

    state_e state_q, state_d;
    logic [2:0]    mode_q, mode_d;
    logic [DW-1:0] value_q, value_d;
    logic [CW-1:0] width_q, width_d, height_q, height_d;
    logic [CW-1:0] row_q, row_d, col_q, col_d;
    logic [STAGES:1] vld_pipe_q, vld_pipe_d;
    logic [DW-1:0] s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;
    logic [CW-1:0] s1_row_q, s1_row_d, s1_col_q, s1_col_d;
    logic          s1_last_q, s1_last_d;
    logic [DW-1:0] s2_r_q, s2_r_d, s2_g_q, s2_g_d, s2_b_q, s2_b_d;
    logic [CW-1:0] s2_row_q, s2_row_d, s2_col_q, s2_col_d;
    logic          s2_last_q, s2_last_d;
    logic          busy_q, busy_d, done_q, done_d;

    logic          adv1, adv2, accept, last_pix, col_wrap, cfg_ok;
    logic [DW-1:0] op_r, op_g, op_b;

    // Stage 2 moves when empty or drained downstream; stage 1 moves when
    // empty or when stage 2 is moving.
    assign adv2     = !vld_pipe_q[2] || out_ready;
    assign adv1     = !vld_pipe_q[1] || adv2;
    assign in_ready = (state_q == RUN) && adv1;
    assign accept   = in_valid && in_ready;
    assign col_wrap = (col_q == width_q - CW'(1));
    assign last_pix = col_wrap && (row_q == height_q - CW'(1));
    assign cfg_ok   = (cfg_width != '0) && (cfg_height != '0) &&
                      (cfg_width <= CW'(MAX_WIDTH)) && (cfg_height <= CW'(MAX_HEIGHT));

    pix_op #(.DW(DW)) u_pix_op (
        .mode  (mode_q),
        .value (value_q),
        .in_r  (s1_r_q),
        .in_g  (s1_g_q),
        .in_b  (s1_b_q),
        .out_r (op_r),
        .out_g (op_g),
        .out_b (op_b)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        value_d    = value_q;
        width_d    = width_q;
        height_d   = height_q;
        row_d      = row_q;
        col_d      = col_q;
        vld_pipe_d = vld_pipe_q;
        s1_r_d = s1_r_q;  s1_g_d = s1_g_q;  s1_b_d = s1_b_q;
        s1_row_d = s1_row_q;  s1_col_d = s1_col_q;  s1_last_d = s1_last_q;
        s2_r_d = s2_r_q;  s2_g_d = s2_g_q;  s2_b_d = s2_b_q;
        s2_row_d = s2_row_q;  s2_col_d = s2_col_q;  s2_last_d = s2_last_q;

        case (state_q)
            IDLE: begin
                if (start && cfg_ok) begin
                    state_d  = RUN;
                    mode_d   = cfg_mode;
                    value_d  = cfg_value;
                    width_d  = cfg_width;
                    height_d = cfg_height;
                    row_d    = '0;
                    col_d    = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_wrap) begin
                        col_d = '0;
                        row_d = row_q + CW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (last_pix) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (vld_pipe_q == '0) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (adv1) begin
            vld_pipe_d[1] = accept;
            if (accept) begin
                s1_r_d = in_r;  s1_g_d = in_g;  s1_b_d = in_b;
                s1_row_d  = row_q;
                s1_col_d  = col_q;
                s1_last_d = last_pix;
            end
        end
        if (adv2) begin
            vld_pipe_d[2] = vld_pipe_q[1];
            if (vld_pipe_q[1]) begin
                s2_r_d = op_r;  s2_g_d = op_g;  s2_b_d = op_b;
                s2_row_d  = s1_row_q;
                s2_col_d  = s1_col_q;
                s2_last_d = s1_last_q;
            end
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            value_q    <= '0;
            width_q    <= '0;
            height_q   <= '0;
            row_q      <= '0;
            col_q      <= '0;
            vld_pipe_q <= '0;
            s1_r_q <= '0;  s1_g_q <= '0;  s1_b_q <= '0;
            s1_row_q <= '0;  s1_col_q <= '0;  s1_last_q <= 1'b0;
            s2_r_q <= '0;  s2_g_q <= '0;  s2_b_q <= '0;
            s2_row_q <= '0;  s2_col_q <= '0;  s2_last_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            value_q    <= value_d;
            width_q    <= width_d;
            height_q   <= height_d;
            row_q      <= row_d;
            col_q      <= col_d;
            vld_pipe_q <= vld_pipe_d;
            s1_r_q <= s1_r_d;  s1_g_q <= s1_g_d;  s1_b_q <= s1_b_d;
            s1_row_q <= s1_row_d;  s1_col_q <= s1_col_d;  s1_last_q <= s1_last_d;
            s2_r_q <= s2_r_d;  s2_g_q <= s2_g_d;  s2_b_q <= s2_b_d;
            s2_row_q <= s2_row_d;  s2_col_q <= s2_col_d;  s2_last_q <= s2_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign out_valid = vld_pipe_q[2];
    assign out_r     = s2_r_q;
    assign out_g     = s2_g_q;
    assign out_b     = s2_b_q;
    assign out_row   = s2_row_q;
    assign out_col   = s2_col_q;
    assign out_last  = s2_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pixel_proc_stream.sv
// Self-checking bench for pixel_proc_stream: directed and randomized frames
// compared against an arithmetic reference model and an expected-output queue.
module tb_pixel_proc_stream;

    localparam int DW   = 8;
    localparam int CW   = 11;
    localparam int MAXV = 255;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    cfg_mode = '0;
    logic [DW-1:0] cfg_value = '0;
    logic [CW-1:0] cfg_width = '0, cfg_height = '0;
    logic          in_valid = 1'b0, in_ready;
    logic [DW-1:0] in_r = '0, in_g = '0, in_b = '0;
    logic          out_valid, out_ready = 1'b0;
    logic [DW-1:0] out_r, out_g, out_b;
    logic [CW-1:0] out_row, out_col;
    logic          out_last, busy, done;

    pixel_proc_stream dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
        .cfg_mode(cfg_mode), .cfg_value(cfg_value),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 HCLK = ~HCLK;

    typedef struct { int r; int g; int b; } pix_t;
    typedef struct { int r; int g; int b; int row; int col; int last; } exp_t;

    int   n_chk = 0;
    int   n_fail = 0;
    pix_t src[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clip(input int x);
        return (x < 0) ? 0 : (x > MAXV) ? MAXV : x;
    endfunction

    // Reference: each mode written straight from its arithmetic definition.
    function automatic pix_t model(input int m, input int v, input pix_t p);
        pix_t o;
        int   gray;
        gray = (p.r + p.g + p.b) / 3;
        o = p;
        case (m)
            1: begin o.r = clip(p.r + v); o.g = clip(p.g + v); o.b = clip(p.b + v); end
            2: begin o.r = clip(p.r - v); o.g = clip(p.g - v); o.b = clip(p.b - v); end
            3: begin o.r = gray; o.g = gray; o.b = gray; end
            4: begin o.r = MAXV - p.r; o.g = MAXV - p.g; o.b = MAXV - p.b; end
`ifdef THRESHOLD_EN
            5: begin o.r = (gray > v) ? MAXV : 0; o.g = o.r; o.b = o.r; end
`endif
            default: o = p;
        endcase
        return o;
    endfunction

    task automatic fill_rand(input int n);
        pix_t p;
        src.delete();
        for (int i = 0; i < n; i++) begin
            p.r = $urandom_range(MAXV); p.g = $urandom_range(MAXV); p.b = $urandom_range(MAXV);
            src.push_back(p);
        end
    endtask

    task automatic fill_const(input int n, input int r, input int g, input int b);
        pix_t p;
        src.delete();
        p.r = r; p.g = g; p.b = b;
        for (int i = 0; i < n; i++) src.push_back(p);
    endtask

    task automatic do_start(input int mode, input int val, input int w, input int h);
        @(negedge HCLK);
        cfg_mode = 3'(mode); cfg_value = DW'(val);
        cfg_width = CW'(w); cfg_height = CW'(h);
        start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
    endtask

    // Runs one frame from src[]; config inputs are scrambled (and start pulsed)
    // mid-frame, which must have no effect.
    task automatic run_frame(input int mode, input int val, input int w, input int h,
                             input int ostall, input int igap);
        exp_t eq[$];
        int   acc[$];
        int   n, sent, got, cyc;
        bit   hold;
        exp_t held, e;
        pix_t m;
        n = w * h; sent = 0; got = 0; cyc = 0; hold = 1'b0;
        for (int i = 0; i < n; i++) begin
            m = model(mode, val, src[i]);
            e.r = m.r; e.g = m.g; e.b = m.b;
            e.row = i / w; e.col = i % w; e.last = (i == n - 1) ? 1 : 0;
            eq.push_back(e);
        end
        do_start(mode, val, w, h);
        #1 chk("busy_after_start", int'(busy), 1);
        while (got < n && cyc < 4000) begin
            out_ready = ($urandom_range(99) >= ostall);
            in_valid  = (sent < n) && ($urandom_range(99) >= igap);
            if (sent < n) begin
                in_r = DW'(src[sent].r); in_g = DW'(src[sent].g); in_b = DW'(src[sent].b);
            end else begin
                in_r = DW'($urandom); in_g = DW'($urandom); in_b = DW'($urandom);
            end
            cfg_mode = 3'($urandom); cfg_value = DW'($urandom);
            cfg_width = CW'($urandom); cfg_height = CW'($urandom);
            start = ($urandom_range(9) == 0);
            #1;
            if (ostall == 0 && sent < n && in_valid) chk("in_ready_full", int'(in_ready), 1);
            if (hold) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_r", int'(out_r), held.r);
                chk("stall_g", int'(out_g), held.g);
                chk("stall_b", int'(out_b), held.b);
                chk("stall_row", int'(out_row), held.row);
                chk("stall_col", int'(out_col), held.col);
                chk("stall_last", int'(out_last), held.last);
            end
            hold = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (eq.size() == 0) begin
                        chk("extra_output", 1, 0);
                    end else begin
                        e = eq.pop_front();
                        chk("out_r", int'(out_r), e.r);
                        chk("out_g", int'(out_g), e.g);
                        chk("out_b", int'(out_b), e.b);
                        chk("out_row", int'(out_row), e.row);
                        chk("out_col", int'(out_col), e.col);
                        chk("out_last", int'(out_last), e.last);
                        if (acc.size() > 0) begin
                            if (ostall == 0) chk("latency", cyc - acc[0], 2);
                            void'(acc.pop_front());
                        end
                    end
                    got++;
                end else begin
                    hold = 1'b1;
                    held.r = int'(out_r); held.g = int'(out_g); held.b = int'(out_b);
                    held.row = int'(out_row); held.col = int'(out_col); held.last = int'(out_last);
                end
            end
            if (in_valid && in_ready) begin
                acc.push_back(cyc);
                sent++;
            end
            @(negedge HCLK);
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("frame_outputs", got, n);
        chk("frame_inputs", sent, n);
        // Pipeline just emptied: still DRAIN this cycle, DONE the next.
        #1;
        chk("drain_out_valid", int'(out_valid), 0);
        chk("drain_busy", int'(busy), 1);
        chk("drain_done", int'(done), 0);
        @(negedge HCLK); #1;
        chk("done_pulse", int'(done), 1);
        chk("done_busy", int'(busy), 0);
        @(negedge HCLK); #1;
        chk("done_clear", int'(done), 0);
        chk("idle_in_ready", int'(in_ready), 0);
    endtask

    task automatic check_ignored(input string tag, input int w, input int h);
        do_start(0, 0, w, h);
        #1 chk(tag, int'(busy), 0);
        chk({tag, "_rdy"}, int'(in_ready), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_out_pix"}, int'(out_r) + int'(out_g) + int'(out_b), 0);
        chk({tag, "_out_coord"}, int'(out_row) + int'(out_col), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent;
        int stalls[3];
        stalls[0] = 0; stalls[1] = 30; stalls[2] = 50;

        repeat (3) @(negedge HCLK);
        #1 check_reset_outputs("reset");
        HRESETn = 1'b1;

        // Saturating add / subtract.
        fill_const(1, 200, 50, 0);
        run_frame(1, 100, 1, 1, 0, 0);
        fill_const(1, 50, 150, 100);
        run_frame(2, 100, 1, 1, 0, 0);

        // Gray on a 4x2 frame: coordinates, out_last, done timing.
        fill_const(8, 10, 20, 31);
        run_frame(3, 0, 4, 2, 0, 0);

        // 3x3 frame with 50% output stalls.
        fill_rand(9);
        run_frame(4, 0, 3, 3, 50, 0);

        // Threshold boundary: gray 91 vs 90 against value 90.
        src.delete();
        begin
            pix_t p;
            p.r = 100; p.g = 90; p.b = 83; src.push_back(p);
            p.r = 90;  p.g = 90; p.b = 90; src.push_back(p);
        end
        run_frame(5, 90, 2, 1, 0, 0);

        // Illegal frame sizes are ignored.
        check_ignored("ign_w0", 0, 4);
        check_ignored("ign_h0", 4, 0);
        check_ignored("ign_wmax", 769, 1);
        check_ignored("ign_hmax", 1, 513);

        // Largest legal width.
        fill_rand(768);
        run_frame(0, 0, 768, 1, 0, 0);

        // Randomized frames.
        for (int k = 0; k < 10; k++) begin
            int w, h;
            w = $urandom_range(6, 1);
            h = $urandom_range(4, 1);
            fill_rand(w * h);
            run_frame($urandom_range(7), $urandom_range(MAXV), w, h,
                      stalls[$urandom_range(2)], 25 * $urandom_range(1));
        end

        // Reset mid-frame after 5 of 16 pixels.
        do_start(1, 10, 4, 4);
        out_ready = 1'b1;
        sent = 0;
        for (int c = 0; c < 50 && sent < 5; c++) begin
            in_valid = 1'b1;
            in_r = DW'($urandom); in_g = DW'($urandom); in_b = DW'($urandom);
            #1;
            if (in_ready) sent++;
            @(negedge HCLK);
        end
        chk("partial_sent", sent, 5);
        in_valid = 1'b0;
        HRESETn = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge HCLK);
        HRESETn = 1'b1;
        fill_rand(16);
        run_frame(2, 40, 4, 4, 30, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
